vx_barrier_unit: RTL
====================

# VX_barrier_unit

Per-core warp barrier controller that sequences barrier requests from the issue stage and releases blocked warps to the warp scheduler. Each barrier accumulates an arrival mask until the requested warp count is reached. It then emits a single release with the full warp mask and clears the barrier. The unit also drives a stall mask that the scheduler uses to gate issue.

## Interface
- NUM_WARPS, 4: warps per core (power of two, ≥2); NW_BITS = clog2(NUM_WARPS)
- NUM_BARRIERS, 4: barrier slots (power of two, ≥1); NB_BITS = max(1, clog2(NUM_BARRIERS))
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  barrier arrival request
- req_ready  out  1  unit can accept a request
- req_wid  in  NW_BITS  arriving warp
- req_id  in  NB_BITS  barrier slot
- req_size_m1  in  NW_BITS  participating warps minus one
- kill_valid  in  1  warp terminated (TMC with empty mask)
- kill_wid  in  NW_BITS  terminated warp
- stalled_wmask  out  NUM_WARPS  warps blocked on any barrier or on a pending release
- rel_valid  out  1  release available
- rel_ready  in  1  scheduler accepts release
- rel_id  out  NB_BITS  released barrier
- rel_wmask  out  NUM_WARPS  warps to unblock
- dup_err  out  1  one-cycle pulse: arrival from a warp already waiting on that barrier

## Operation
- Per-slot state: mask[NUM_WARPS], size_m1[NW_BITS], active bit. One release register holds {rel_valid, rel_id, rel_wmask}.
- Accept: req_valid && req_ready at a clock edge. req_ready = !rel_valid.
- First arrival on an inactive slot sets active and latches req_size_m1. Later arrivals use the latched size and ignore req_size_m1.
- Let new = mask | (1<<req_wid). If popcount(new) == size_m1+1, computed at NW_BITS+1 width, the barrier completes:
  - the release register loads {1, req_id, new};
  - the slot is cleared (mask=0, active=0).
  - Otherwise mask <= new.
- size_m1 == 0: the arrival completes immediately. The warp appears in stalled_wmask only until the release handshake.
- Duplicate arrival (req_wid bit already set): no state change; dup_err pulses the next cycle; the request is still consumed.
- Kill: clears bit kill_wid in every slot mask and in rel_wmask.
  - A slot whose mask reaches 0 goes inactive.
  - A kill never triggers completion.
  - If kill empties rel_wmask, rel_valid stays asserted with a zero mask. The scheduler must tolerate this.
- Kill and an accepted request for the same warp in one cycle: kill wins, and the arrival is discarded (still consumed).
- Kill and an accepted request for different warps on the same slot: the completion check uses the mask after the kill is applied.
- Release handshake rel_valid && rel_ready clears rel_valid. req_ready returns high the following cycle.
- stalled_wmask = OR of all slot masks | (rel_valid ? rel_wmask : 0). It is combinational from registered state.

## Timing
- Reset values: all masks 0, active 0, size_m1 0, rel_valid 0, rel_id 0, rel_wmask 0, dup_err 0. Hence req_ready 1 and stalled_wmask 0.
- Arrival accepted at edge N: the stalled_wmask bit is visible in cycle N+1.
- Completing arrival at edge N: rel_valid is high from cycle N+1 and held stable until rel_ready.
- rel_ready high in the same cycle rel_valid first rises gives a one-cycle release.
- Back-to-back: after a release handshake at edge M, the next request can be accepted at edge M+1 at the earliest.
- Reset asserted mid-operation clears all state immediately. No release is emitted for partially filled barriers.
- No combinational path from rel_ready or req_* to any output except req_ready, which depends on rel_valid only.

## Structure
- Add to the shared GPU types package:
  - barrier_req_t {wid, id, size_m1};
  - barrier_rel_t {id, wmask};
  - matching width macros alongside the existing barrier width macro.
- One sub-module: VX_barrier_slot. It holds one slot's mask, size, and active bit, and computes its completion flag and popcount. The top instantiates NUM_BARRIERS copies plus the release register and arbitration glue.

## Test plan
- 4-warp barrier 0, size_m1=3; warps 0,1,2,3 arrive on consecutive cycles. Required: stalled_wmask grows 0001→0111, then rel_valid=1, rel_wmask=1111, rel_id=0, and stalled_wmask=1111 until handshake, then 0000.
- size_m1=0 arrival from warp 2 on barrier 1. Required: rel_valid next cycle, rel_wmask=0100, slot inactive.
- Warp 1 arrives twice at barrier 2 (size_m1=2). Required: dup_err pulses once, mask stays 0010, no release.
- Warps 0,1 wait on barrier 3 (size_m1=2); kill warp 1, then warp 2 arrives. Required: no release (popcount 2 < 3); mask=0101.
- Release pending with rel_ready=0 for 5 cycles while req_valid=1. Required: req_ready=0 throughout, rel_* stable. Then rel_ready=1 → request accepted the cycle after the handshake.
- Assert reset with barrier 0 holding 0011 and a release pending. Required: all outputs return to reset values within the same cycle, and no release is emitted after deassertion.

Source files
------------

// File: rtl/vx_barrier_unit_pkg.sv
// Shared barrier types for the per-core barrier unit.
// Holds the default warp/barrier geometry, the derived field widths, the request and
// release bundles, and a small one-hot helper.
package vx_barrier_unit_pkg;

  localparam int unsigned BAR_NUM_WARPS    = 4;
  localparam int unsigned BAR_NUM_BARRIERS = 4;
  localparam int unsigned BAR_NW_BITS      = $clog2(BAR_NUM_WARPS);
  localparam int unsigned BAR_NB_BITS      = (BAR_NUM_BARRIERS > 1) ? $clog2(BAR_NUM_BARRIERS) : 1;

  typedef struct packed {
    logic [BAR_NW_BITS-1:0] wid;
    logic [BAR_NB_BITS-1:0] id;
    logic [BAR_NW_BITS-1:0] size_m1;
  } barrier_req_t;

  typedef struct packed {
    logic [BAR_NB_BITS-1:0]   id;
    logic [BAR_NUM_WARPS-1:0] wmask;
  } barrier_rel_t;

  function automatic logic [BAR_NUM_WARPS-1:0] wid_onehot(input logic [BAR_NW_BITS-1:0] wid);
    return BAR_NUM_WARPS'(1) << wid;
  endfunction

endpackage

// File: rtl/vx_barrier_unit_slot.sv
// One barrier slot: arrival mask, latched participant count and active bit.
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_kill_valid/i_kill_wid warp termination, clears the warp's bit
//   i_arr_valid             accepted arrival targeting this slot (already filtered for kill)
//   i_arr_wid, i_size_m1    arriving warp and requested participant count minus one
//   o_mask, o_active        current slot state
//   o_dup                   arriving warp is already waiting here
//   o_complete              this arrival fills the barrier
//   o_new_mask              post-kill mask with the arriving warp added (release payload)
module vx_barrier_unit_slot #(
  parameter int unsigned NUM_WARPS = 4,
  parameter int unsigned NW_BITS   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_kill_valid,
  input  logic [NW_BITS-1:0]   i_kill_wid,
  input  logic                 i_arr_valid,
  input  logic [NW_BITS-1:0]   i_arr_wid,
  input  logic [NW_BITS-1:0]   i_size_m1,
  output logic [NUM_WARPS-1:0] o_mask,
  output logic                 o_active,
  output logic                 o_dup,
  output logic                 o_complete,
  output logic [NUM_WARPS-1:0] o_new_mask
);

  logic [NUM_WARPS-1:0] r_mask;
  logic [NW_BITS-1:0]   r_size_m1;
  logic                 r_active;

  logic [NUM_WARPS-1:0] w_kill_mask;
  logic [NUM_WARPS-1:0] w_mask_k;
  logic [NUM_WARPS-1:0] w_new;
  logic [NW_BITS-1:0]   w_size;
  logic [NW_BITS:0]     w_popcnt;
  logic                 w_arr;
  logic                 w_full;

  assign w_kill_mask = i_kill_valid ? (NUM_WARPS'(1) << i_kill_wid) : '0;
  // Completion is judged against the mask with the same-cycle kill already applied.
  assign w_mask_k    = r_mask & ~w_kill_mask;
  assign w_new       = w_mask_k | (NUM_WARPS'(1) << i_arr_wid);
  // First arrival supplies the size; later arrivals use the latched one.
  assign w_size      = r_active ? r_size_m1 : i_size_m1;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < int'(NUM_WARPS); i++) begin
      w_popcnt = w_popcnt + (NW_BITS+1)'(w_new[i]);
    end
  end

  assign o_dup      = r_mask[i_arr_wid];
  assign w_arr      = i_arr_valid && !o_dup;
  assign w_full     = (w_popcnt == ({1'b0, w_size} + (NW_BITS+1)'(1)));
  assign o_complete = w_arr && w_full;
  assign o_new_mask = w_new;
  assign o_mask     = r_mask;
  assign o_active   = r_active;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mask    <= '0;
      r_size_m1 <= '0;
      r_active  <= 1'b0;
    end else if (w_arr && w_full) begin
      r_mask   <= '0;
      r_active <= 1'b0;
    end else if (w_arr) begin
      r_mask   <= w_new;
      r_active <= 1'b1;
      if (!r_active) r_size_m1 <= i_size_m1;
    end else begin
      // Kill only: a slot drained to zero goes idle, never completes.
      r_mask   <= w_mask_k;
      r_active <= r_active && (|w_mask_k);
    end
  end

endmodule

// File: rtl/vx_barrier_unit.sv
// Per-core warp barrier controller.
// Collects barrier arrivals from issue, emits one release per filled barrier and drives
// the scheduler stall mask.
// Ports:
//   i_clk, i_reset                       clock, async active-high reset
//   i_req_valid/o_req_ready              arrival handshake (ready = no release pending)
//   i_req_wid, i_req_id, i_req_size_m1   arriving warp, barrier slot, participants - 1
//   i_kill_valid, i_kill_wid             warp termination
//   o_stalled_wmask                      warps waiting on a barrier or pending release
//   o_rel_valid/i_rel_ready              release handshake
//   o_rel_id, o_rel_wmask                released barrier and warps to unblock
//   o_dup_err                            one-cycle pulse for a duplicate arrival
// The package geometry must match NUM_WARPS/NUM_BARRIERS.
module vx_barrier_unit
  import vx_barrier_unit_pkg::*;
#(
  parameter int unsigned NUM_WARPS    = BAR_NUM_WARPS,
  parameter int unsigned NUM_BARRIERS = BAR_NUM_BARRIERS,
  parameter int unsigned NW_BITS      = $clog2(NUM_WARPS),
  parameter int unsigned NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [NW_BITS-1:0]   i_req_wid,
  input  logic [NB_BITS-1:0]   i_req_id,
  input  logic [NW_BITS-1:0]   i_req_size_m1,
  input  logic                 i_kill_valid,
  input  logic [NW_BITS-1:0]   i_kill_wid,
  output logic [NUM_WARPS-1:0] o_stalled_wmask,
  output logic                 o_rel_valid,
  input  logic                 i_rel_ready,
  output logic [NB_BITS-1:0]   o_rel_id,
  output logic [NUM_WARPS-1:0] o_rel_wmask,
  output logic                 o_dup_err
);

  barrier_req_t w_req;
  barrier_rel_t r_rel;
  logic         r_rel_valid;
  logic         r_dup_err;

  logic                 w_accept;
  logic                 w_kill_same;
  logic                 w_arr_ok;
  logic                 w_dup_sel;
  logic [NUM_BARRIERS-1:0] w_slot_complete;
  logic [NUM_BARRIERS-1:0] w_slot_dup;
  logic [NUM_BARRIERS-1:0] w_slot_active;
  logic [NUM_WARPS-1:0]    w_slot_mask [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]    w_slot_new  [NUM_BARRIERS];

  assign w_req.wid     = i_req_wid;
  assign w_req.id      = i_req_id;
  assign w_req.size_m1 = i_req_size_m1;

  assign o_req_ready = !r_rel_valid;
  assign w_accept    = i_req_valid && !r_rel_valid;
  // Kill wins over an arrival from the same warp; the request is still consumed.
  assign w_kill_same = i_kill_valid && (i_kill_wid == w_req.wid);
  assign w_arr_ok    = w_accept && !w_kill_same;
  assign w_dup_sel   = w_arr_ok && w_slot_dup[w_req.id];

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : gen_slot
    vx_barrier_unit_slot #(
      .NUM_WARPS (NUM_WARPS),
      .NW_BITS   (NW_BITS)
    ) u_slot (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_kill_valid (i_kill_valid),
      .i_kill_wid   (i_kill_wid),
      .i_arr_valid  (w_arr_ok && (w_req.id == NB_BITS'(b))),
      .i_arr_wid    (w_req.wid),
      .i_size_m1    (w_req.size_m1),
      .o_mask       (w_slot_mask[b]),
      .o_active     (w_slot_active[b]),
      .o_dup        (w_slot_dup[b]),
      .o_complete   (w_slot_complete[b]),
      .o_new_mask   (w_slot_new[b])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rel_valid <= 1'b0;
      r_rel       <= '0;
      r_dup_err   <= 1'b0;
    end else begin
      r_dup_err <= w_dup_sel;
      // Completion only happens while no release is pending, so it never races the handshake.
      if (|w_slot_complete) begin
        r_rel_valid <= 1'b1;
        r_rel.id    <= w_req.id;
        r_rel.wmask <= w_slot_new[w_req.id];
      end else begin
        if (r_rel_valid && i_rel_ready) r_rel_valid <= 1'b0;
        // A kill may empty the pending mask; the release still goes out with zero warps.
        if (i_kill_valid) r_rel.wmask <= r_rel.wmask & ~wid_onehot(i_kill_wid);
      end
    end
  end

  always_comb begin
    o_stalled_wmask = r_rel_valid ? r_rel.wmask : '0;
    for (int b = 0; b < int'(NUM_BARRIERS); b++) begin
      o_stalled_wmask = o_stalled_wmask | w_slot_mask[b];
    end
  end

  assign o_rel_valid = r_rel_valid;
  assign o_rel_id    = r_rel.id;
  assign o_rel_wmask = r_rel.wmask;
  assign o_dup_err   = r_dup_err;

  // Active bits are observable state only; the masks alone drive stall and completion.
  logic w_unused_active;
  assign w_unused_active = ^w_slot_active;

endmodule
